// File: rtl/alu_operand_sequencer_if.sv
// Board-side bundle for the ALU operand sequencer: switch/button inputs, ALU result
// return path, and the registered operand/result/status outputs.
interface alu_operand_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 6
);
   logic [DATA_W-1:0] SW;
   logic              BTN;
   logic [DATA_W-1:0] Z;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic [OP_W-1:0]   OP;
   logic              START;
   logic [DATA_W-1:0] LED;
   logic              DONE;
   logic [2:0]        STATE;

   modport master (
      input  SW, BTN, Z,
      output A, B, OP, START, LED, DONE, STATE
   );

   modport slave (
      output SW, BTN, Z,
      input  A, B, OP, START, LED, DONE, STATE
   );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Steps A, B, OP in from switches on button presses, pulses START and latches Z into LED.
// Optional button debounce filter is enabled with `define DEBOUNCE_EN.
module alu_operand_sequencer #(
   parameter int DATA_W    = 8,
   parameter int OP_W      = 6,
   parameter int DB_CYCLES = 4
) (
   input  logic                   CLK,
   input  logic                   RESET,
   alu_operand_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   state_t            state_q, state_nxt;
   logic              s1, s2, s3, accepted, press;
   logic              ld_a, ld_b, ld_op, ld_led;
   logic [DATA_W-1:0] a_q, b_q, led_q;
   logic [OP_W-1:0]   op_q;

   // BTN is asynchronous; s3 remembers the last accepted level for edge detection
   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.BTN;
         s2 <= s1;
         s3 <= accepted;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   logic [CNT_W-1:0] db_cnt;
   logic             db_lvl;

   // s2 must disagree with the accepted level for DB_CYCLES straight cycles to flip it
   always_ff @(posedge CLK) begin
      if (RESET) begin
         db_cnt <= '0;
         db_lvl <= 1'b0;
      end else if (s2 == db_lvl) begin
         db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
         db_cnt <= '0;
         db_lvl <= s2;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   assign accepted = db_lvl;
`else
   assign accepted = s2;
`endif

   assign press = accepted & ~s3;

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_A;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      ld_op     = 1'b0;
      ld_led    = 1'b0;
      case (state_q)
         S_A:    if (press) begin ld_a  = 1'b1; state_nxt = S_B;    end
         S_B:    if (press) begin ld_b  = 1'b1; state_nxt = S_OP;   end
         S_OP:   if (press) begin ld_op = 1'b1; state_nxt = S_EXEC; end
         S_EXEC: begin
            ld_led    = 1'b1;
            state_nxt = S_SHOW;
         end
         S_SHOW: if (press) state_nxt = S_A;
         default: state_nxt = S_A;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         led_q <= '0;
      end else begin
         if (ld_a)   a_q   <= bus.SW;
         if (ld_b)   b_q   <= bus.SW;
         if (ld_op)  op_q  <= bus.SW[OP_W-1:0];
         if (ld_led) led_q <= bus.Z;
      end
   end

   assign bus.A     = a_q;
   assign bus.B     = b_q;
   assign bus.OP    = op_q;
   assign bus.LED   = led_q;
   assign bus.STATE = state_q;
   assign bus.START = (state_q == S_EXEC);
   assign bus.DONE  = (state_q == S_SHOW);

endmodule
